median3x3_stream: RTL

- Streaming 3x3 median filter for packed multi-channel images.
- Replaces whole-row-per-clock filtering with a pixel-per-clock valid/ready stream. Two internal line buffers hold the previous rows.
- Generalised in pixel width, channel count and frame geometry. Uses a true 9-input median per channel with edge replication on all four borders.
- Sits between the raw image source (padded multi-channel input) and the frame sink.

---
 rtl/median3x3_stream_pkg.sv | 18 +
 rtl/median3x3_stream_median9.sv | 21 ++
 rtl/median3x3_stream.sv | 129 ++++++++++++
 3 files changed

// File: rtl/median3x3_stream_pkg.sv
// median_pkg: shared defaults, FSM states and counter sizing for median3x3_stream.
package median_pkg;
  localparam int DEF_W = 8;
  localparam int DEF_CH = 3;
  localparam int DEF_COLS = 1920;
  localparam int DEF_ROWS = 1080;
  typedef enum logic [1:0] {ROW0, RUN, FLUSH} state_t;
  function automatic int cnt_w(input int n);
    return n < 2 ? 1 : $clog2(n);
  endfunction
  function automatic int out_ch(input int ch);
`ifdef ALPHA_PASS_EN
    return ch + 1;
`else
    return ch;
`endif
  endfunction
endpackage

// File: rtl/median3x3_stream_median9.sv
// median9: combinational 19-exchange network returning the median of nine W-bit values.
module median9 #(
  parameter int W = 8
) (
  input  logic [9*W-1:0] win_i,
  output logic [W-1:0]   med_o
);
  localparam int A [19] = '{1, 4, 7, 0, 3, 6, 1, 4, 7, 0, 5, 4, 3, 1, 2, 4, 4, 6, 4};
  localparam int B [19] = '{2, 5, 8, 1, 4, 7, 2, 5, 8, 3, 8, 7, 6, 4, 5, 7, 2, 4, 2};
  always_comb begin
    logic [W-1:0] v [9];
    logic [W-1:0] t;
    for (int i = 0; i < 9; i++) v[i] = win_i[i*W +: W];
    for (int i = 0; i < 19; i++) begin
      t = v[A[i]];
      v[A[i]] = t > v[B[i]] ? v[B[i]] : t;
      v[B[i]] = t > v[B[i]] ? t : v[B[i]];
    end
    med_o = v[4];
  end
endmodule

// File: rtl/median3x3_stream.sv
// median3x3_stream: pixel-per-clock 3x3 median filter with edge replication.
// ALPHA_PASS_EN forwards the window-centre padding channel as an extra output channel.
module median3x3_stream
  import median_pkg::*;
#(
  parameter int W = DEF_W,
  parameter int CH = DEF_CH,
  parameter int COLS = DEF_COLS,
  parameter int ROWS = DEF_ROWS
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [(CH+1)*W-1:0]      in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [out_ch(CH)*W-1:0]  out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_sof,
  output logic                     out_eol,
  output logic                     frame_done
);
  localparam int PW = (CH + 1) * W;
  localparam int XW = CH * W;
  localparam int OW = out_ch(CH) * W;
  localparam int CW = cnt_w(COLS);
  localparam int RW = cnt_w(ROWS + 1);

  state_t          state_q;
  logic [CW-1:0]   col_q;
  logic [RW-1:0]   row_q;
  logic            tail_q, top_q, last_q;
  logic [PW-1:0]   lb0_q [COLS];
  logic [PW-1:0]   lb1_q [COLS];
  logic [3*XW-1:0] p2_q, p1_q, cur, rt;
  logic [XW-1:0]   ab, ce, be;
  logic [OW-1:0]   med;
  logic            adv, acc, rd, step, col_end, ld;

  assign adv = !out_valid || out_ready;
  assign in_ready = adv && state_q != FLUSH && !tail_q;
  assign acc = in_valid && in_ready;
  assign rd = (state_q == RUN && acc) || (state_q == FLUSH && adv && !tail_q);
  assign step = rd || (state_q == ROW0 && acc);
  assign col_end = col_q == CW'(COLS - 1);
  assign ld = adv && ((rd && col_q != '0) || tail_q);

  // Column entering the window: {below, centre, above}; rows clamp at top and bottom.
  assign ce = lb1_q[col_q][XW-1:0];
  assign ab = top_q ? ce : lb0_q[col_q][XW-1:0];
  assign be = state_q == FLUSH ? ce : in_data[XW-1:0];
  assign cur = {be, ce, ab};
  assign rt = rd ? cur : p1_q;

  for (genvar k = 0; k < CH; k++) begin : g_med
    median9 #(.W(W)) u_med (
      .win_i({rt[2*XW+k*W +: W], rt[XW+k*W +: W], rt[k*W +: W],
              p1_q[2*XW+k*W +: W], p1_q[XW+k*W +: W], p1_q[k*W +: W],
              p2_q[2*XW+k*W +: W], p2_q[XW+k*W +: W], p2_q[k*W +: W]}),
      .med_o(med[k*W +: W])
    );
  end

`ifdef ALPHA_PASS_EN
  logic [W-1:0] pad_q;
  assign med[XW +: W] = pad_q;
  always_ff @(posedge CLK or negedge RST)
    if (!RST) pad_q <= '0;
    else if (rd) pad_q <= lb1_q[col_q][XW +: W];
`endif

  always_ff @(posedge CLK)
    if (acc) begin
      if (state_q == RUN) lb0_q[col_q] <= lb1_q[col_q];
      lb1_q[col_q] <= in_data;
    end

  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      state_q <= ROW0;
      col_q <= '0;
      row_q <= '0;
      tail_q <= 1'b0;
      top_q <= 1'b0;
      last_q <= 1'b0;
      p2_q <= '0;
      p1_q <= '0;
      out_valid <= 1'b0;
      out_sof <= 1'b0;
      out_eol <= 1'b0;
      out_data <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= out_valid && out_ready && last_q;
      if (adv) begin
        out_valid <= ld;
        out_sof <= ld && !tail_q && state_q == RUN && row_q == RW'(1) && col_q == CW'(1);
        out_eol <= ld && tail_q;
        if (ld) begin
          out_data <= med;
          last_q <= tail_q && state_q == FLUSH;
        end
      end
      if (rd) begin
        p2_q <= col_q == '0 ? cur : p1_q;
        p1_q <= cur;
      end
      if (step) begin
        col_q <= col_end ? '0 : col_q + CW'(1);
        tail_q <= col_end && state_q != ROW0;
        if (col_end && state_q == ROW0) begin
          state_q <= RUN;
          row_q <= RW'(1);
          top_q <= 1'b1;
        end
      end
      if (tail_q && adv) begin
        tail_q <= 1'b0;
        top_q <= 1'b0;
        if (state_q == FLUSH) begin
          state_q <= ROW0;
          row_q <= '0;
        end else begin
          row_q <= row_q + RW'(1);
          if (row_q == RW'(ROWS - 1)) state_q <= FLUSH;
        end
      end
    end
endmodule
